// File: rtl/posit_decode_arbiter.sv
// posit_decode_arbiter
//   Two requesters share one combinational posit decoder. A round-robin
//   arbiter picks a requester. The decoded fields are captured into a
//   one-entry result register with a valid/ready handshake. The register is
//   reloaded in the same cycle it is drained, so the block can deliver one
//   result per clock.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in0_valid/in0_bits/in0_ready   requester 0 offer and acceptance
//   in1_valid/in1_bits/in1_ready   requester 1 offer and acceptance
//   out_valid/out_ready         result register handshake
//   out_id                      requester that produced the held result
//   out_is_zero, out_is_inf     special-value flags
//   out_sign                    posit sign bit
//   out_reg_s                   regime sign (value of the first regime bit)
//   out_reg_len                 regime length in bits, including the terminator
//   out_k                       regime value k (two's complement, N bits)
//   out_exp                     exponent field (at least 1 bit wide when ES=0)
//   out_mant                    fraction bits, right-aligned, no hidden bit
//
// posit_decode (helper, same file)
//   Purely combinational decode of one posit word.
//   Negative posits are decoded from their two's-complement magnitude.
//   For zero and NaR (inf), only the flags and the sign are non-zero.

module posit_decode #(
  parameter int N  = 8,
  parameter int ES = 0,
  parameter int S  = $clog2(N),
  parameter int EW = (ES > 0) ? ES : 1
) (
  input  logic [N-1:0]  bits,
  output logic          is_zero,
  output logic          is_inf,
  output logic          sign,
  output logic          reg_s,
  output logic [S-1:0]  reg_len,
  output logic [N-1:0]  k,
  output logic [EW-1:0] exp,
  output logic [N-1:0]  mant
);

  logic [N-1:0] mag;
  logic [N-2:0] body;
  int           run;
  int           rl;
  int           frac_bits;
  int           pos;
  logic         done;

  always_comb begin
    sign      = bits[N-1];
    is_zero   = (bits == '0);
    is_inf    = (bits == {1'b1, {(N-1){1'b0}}});
    mag       = sign ? (~bits + 1'b1) : bits;
    body      = mag[N-2:0];

    // Length of the run of identical leading bits after the sign.
    run  = 0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done) begin
        if (body[i] == body[N-2]) run = run + 1;
        else                      done = 1'b1;
      end
    end

    // A run that reaches the LSB has no terminating bit.
    rl      = (run == N - 1) ? run : run + 1;
    reg_s   = body[N-2];
    k       = reg_s ? N'(run - 1) : N'(0 - run);
    reg_len = S'(rl);

    // Exponent bits cut off at the end of the word read as zero.
    exp = '0;
    pos = 0;
    for (int j = 0; j < ES; j++) begin
      pos = N - 2 - rl - j;
      if (pos >= 0) exp[ES-1-j] = body[pos];
    end

    frac_bits = N - 1 - rl - ES;
    mant      = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (i < frac_bits) mant[i] = body[i];
    end

    if (is_zero || is_inf) begin
      reg_s   = 1'b0;
      k       = '0;
      reg_len = '0;
      exp     = '0;
      mant    = '0;
    end
  end

endmodule

module posit_decode_arbiter #(
  parameter int N  = 8,
  parameter int ES = 0,
  parameter int S  = $clog2(N)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in0_valid,
  input  logic [N-1:0]                  in0_bits,
  output logic                          in0_ready,
  input  logic                          in1_valid,
  input  logic [N-1:0]                  in1_bits,
  output logic                          in1_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_id,
  output logic                          out_is_zero,
  output logic                          out_is_inf,
  output logic                          out_sign,
  output logic                          out_reg_s,
  output logic [S-1:0]                  out_reg_len,
  output logic [N-1:0]                  out_k,
  output logic [((ES > 0) ? ES : 1)-1:0] out_exp,
  output logic [N-1:0]                  out_mant
);

  localparam int EW = (ES > 0) ? ES : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state, state_next;
  logic         last_grant;
  logic         grant;
  logic         accept_ok;
  logic         transfer;
  logic [N-1:0] dec_bits;

  logic          dec_is_zero, dec_is_inf, dec_sign, dec_reg_s;
  logic [S-1:0]  dec_reg_len;
  logic [N-1:0]  dec_k, dec_mant;
  logic [EW-1:0] dec_exp;

  // Round-robin: on contention the requester that did not win last time goes.
  // Grant depends only on the valids and last_grant, never on the data.
  always_comb begin
    if (in0_valid && in1_valid) grant = ~last_grant;
    else                        grant = in1_valid;
  end

  assign dec_bits = grant ? in1_bits : in0_bits;

  posit_decode #(.N(N), .ES(ES), .S(S), .EW(EW)) u_decode (
    .bits    (dec_bits),
    .is_zero (dec_is_zero),
    .is_inf  (dec_is_inf),
    .sign    (dec_sign),
    .reg_s   (dec_reg_s),
    .reg_len (dec_reg_len),
    .k       (dec_k),
    .exp     (dec_exp),
    .mant    (dec_mant)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (transfer) state_next = FULL;
      FULL:    if (out_ready && !transfer) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // FSM: outputs. The ready outputs are gated by rst_n so that they drop
  // the moment reset is asserted.
  always_comb begin
    out_valid = (state == FULL);
    accept_ok = (state == EMPTY) || out_ready;
    in0_ready = rst_n && accept_ok && in0_valid && !grant;
    in1_ready = rst_n && accept_ok && in1_valid &&  grant;
    transfer  = in0_ready || in1_ready;
  end

  // Result register and arbitration history.
  // last_grant resets to 1 so that requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= 1'b1;
      out_id      <= 1'b0;
      out_is_zero <= 1'b0;
      out_is_inf  <= 1'b0;
      out_sign    <= 1'b0;
      out_reg_s   <= 1'b0;
      out_reg_len <= '0;
      out_k       <= '0;
      out_exp     <= '0;
      out_mant    <= '0;
    end else if (transfer) begin
      last_grant  <= grant;
      out_id      <= grant;
      out_is_zero <= dec_is_zero;
      out_is_inf  <= dec_is_inf;
      out_sign    <= dec_sign;
      out_reg_s   <= dec_reg_s;
      out_reg_len <= dec_reg_len;
      out_k       <= dec_k;
      out_exp     <= dec_exp;
      out_mant    <= dec_mant;
    end
  end

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Testbench for posit_decode_arbiter (N=8, ES=0).
// It runs a set of directed scenarios and then randomized traffic.
// Every cycle is compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_posit_decode_arbiter;

  localparam int N = 8;
  localparam int ES = 0;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in0_valid, in1_valid, in0_ready, in1_ready;
  logic [N-1:0] in0_bits, in1_bits;
  logic out_valid, out_ready, out_id;
  logic out_is_zero, out_is_inf, out_sign, out_reg_s;
  logic [S-1:0] out_reg_len;
  logic [N-1:0] out_k, out_mant;
  logic [0:0] out_exp;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic        m_full;
  logic        m_last;
  logic        m_id;
  logic [23:0] m_res;
  logic        obs_r0, obs_r1;
  int          skip0, skip1;

  posit_decode_arbiter #(.N(N), .ES(ES), .S(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_bits(in0_bits), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_bits(in1_bits), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_is_zero(out_is_zero), .out_is_inf(out_is_inf), .out_sign(out_sign),
    .out_reg_s(out_reg_s), .out_reg_len(out_reg_len), .out_k(out_k),
    .out_exp(out_exp), .out_mant(out_mant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want)
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    else
      n_pass++;
  endtask

  // The packed result is {zero, inf, sign, reg_s, reg_len[2:0], k[7:0], exp[0], mant[7:0]}.
  function automatic logic [23:0] ref_decode(input logic [7:0] b);
    int q[$];
    int mag, run, k, rlen, mant, first;
    bit term;
    if (b == 8'h00) return 24'h800000;
    if (b == 8'h80) return 24'h200000 | 24'h400000;
    mag = b[7] ? (256 - int'(b)) : int'(b);
    for (int i = 6; i >= 0; i--) q.push_back((mag >> i) & 1);
    first = q[0];
    run = 0;
    while (q.size() > 0 && q[0] == first) begin
      void'(q.pop_front());
      run++;
    end
    term = (q.size() > 0);
    if (term) void'(q.pop_front());
    rlen = run + (term ? 1 : 0);
    k = (first == 1) ? run - 1 : -run;
    mant = 0;
    foreach (q[i]) mant = mant * 2 + q[i];
    return {1'b0, 1'b0, b[7], first[0], rlen[2:0], k[7:0], 1'b0, mant[7:0]};
  endfunction

  function automatic logic [23:0] dut_res();
    return {out_is_zero, out_is_inf, out_sign, out_reg_s, out_reg_len, out_k, out_exp, out_mant};
  endfunction

  // One clock of traffic: drive the inputs, compare against the model,
  // then advance the model on the rising edge.
  task automatic cycle(input logic v0, input logic [7:0] b0, input logic v1,
                       input logic [7:0] b1, input logic ordy);
    logic acc, g, r0, r1;
    @(negedge clk);
    in0_valid = v0; in0_bits = b0; in1_valid = v1; in1_bits = b1; out_ready = ordy;
    #1;
    acc = !m_full || ordy;
    if (v0 && v1) g = !m_last;
    else          g = v1;
    r0 = acc && v0 && !g;
    r1 = acc && v1 && g;
    obs_r0 = in0_ready;
    obs_r1 = in1_ready;
    check("in0_ready", {31'd0, in0_ready}, {31'd0, r0});
    check("in1_ready", {31'd0, in1_ready}, {31'd0, r1});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    if (m_full) begin
      check("out_id", {31'd0, out_id}, {31'd0, m_id});
      check("result", {8'd0, dut_res()}, {8'd0, m_res});
    end
    // Fairness is measured on the DUT's own handshakes.
    if (v0 && v1 && obs_r0) skip1++;
    if (v0 && v1 && obs_r1) skip0++;
    if (obs_r0) skip0 = 0;
    if (obs_r1) skip1 = 0;
    check("fairness", {30'd0, skip0 > 1, skip1 > 1}, 32'd0);
    @(posedge clk);
    if (r0 || r1) begin
      m_full = 1'b1;
      m_last = g;
      m_id   = g;
      m_res  = ref_decode(g ? b1 : b0);
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  // Assert reset asynchronously between edges and check its immediate effect.
  task automatic do_reset(input string tag);
    #2;
    in0_valid = 1'b1; in1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rdy"}, {30'd0, in0_ready, in1_ready}, 32'd0);
    check({tag, "_id"}, {31'd0, out_id}, 32'd0);
    check({tag, "_data"}, {8'd0, dut_res()}, 32'd0);
    m_full = 1'b0; m_last = 1'b1; m_id = 1'b0; m_res = '0;
    skip0 = 0; skip1 = 0;
    @(negedge clk);
    in0_valid = 1'b0; in1_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in0_valid = 0; in1_valid = 0; in0_bits = 0; in1_bits = 0; out_ready = 0;
    #3;
    do_reset("rst0");

    // single request
    cycle(1, 8'h40, 0, 8'h00, 1);
    check("s1_ready", {31'd0, obs_r0}, 32'd1);
    check("s1_valid", {31'd0, out_valid}, 32'd1);
    check("s1_id", {31'd0, out_id}, 32'd0);
    check("s1_sign", {31'd0, out_sign}, 32'd0);
    check("s1_reg_s", {31'd0, out_reg_s}, 32'd1);
    check("s1_k", {24'd0, out_k}, 32'd0);
    check("s1_reg_len", {29'd0, out_reg_len}, 32'd2);
    check("s1_mant", {24'd0, out_mant}, 32'h00);
    cycle(0, 8'h00, 0, 8'h00, 1);

    // contention starting from a fresh reset
    do_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      cycle(1, 8'h60, 1, 8'h50, 1);
      check("ct_id", {31'd0, out_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 0) begin
        check("ct_k0", {24'd0, out_k}, 32'd1);
        check("ct_len0", {29'd0, out_reg_len}, 32'd3);
      end else begin
        check("ct_k1", {24'd0, out_k}, 32'd0);
        check("ct_mant1", {24'd0, out_mant}, 32'h10);
      end
    end

    // backpressure
    cycle(0, 8'h00, 0, 8'h00, 1);
    cycle(1, 8'h60, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 1, 8'h50, 0);
      check("bp_rdy1", {31'd0, obs_r1}, 32'd0);
      check("bp_k", {24'd0, out_k}, 32'd1);
      check("bp_id", {31'd0, out_id}, 32'd0);
    end
    cycle(0, 8'h00, 1, 8'h50, 1);
    check("bp_accept", {31'd0, obs_r1}, 32'd1);
    check("bp_new_id", {31'd0, out_id}, 32'd1);

    // special values
    cycle(1, 8'h00, 0, 8'h00, 1);
    check("sp_zero", {30'd0, out_is_zero, out_is_inf}, 32'd2);
    cycle(1, 8'h80, 0, 8'h00, 1);
    check("sp_inf", {29'd0, out_is_zero, out_is_inf, out_sign}, 32'd3);

    // drain: last_grant stays with requester 0, so requester 1 wins next contention
    cycle(0, 8'h00, 0, 8'h00, 1);
    check("dr_valid", {31'd0, out_valid}, 32'd0);
    cycle(1, 8'h11, 1, 8'h22, 1);
    check("dr_grant", {30'd0, obs_r0, obs_r1}, 32'd1);

    // reset while FULL; requester 0 must be granted first after release
    cycle(1, 8'h33, 0, 8'h00, 0);
    check("rm_full", {31'd0, out_valid}, 32'd1);
    do_reset("rst2");
    cycle(1, 8'h44, 1, 8'h55, 1);
    check("rm_grant", {30'd0, obs_r0, obs_r1}, 32'd2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, 8'($urandom), ($urandom % 4) != 0, 8'($urandom),
            ($urandom % 4) != 0);
    end
    // exhaustive decode sweep via requester 1
    for (int b = 0; b < 256; b++) begin
      cycle(0, 8'h00, 1, 8'(b), 1);
    end
    cycle(0, 8'h00, 0, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/posit_decode_arbiter.md
POSIT_DECODE_ARBITER -- requirements
Module: posit_decode_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, meaning posit width in bits.
REQ-002 SHALL have parameter ES, default 0, meaning exponent field width.
REQ-003 SHALL have parameter S, default $clog2(N), meaning width of the regime-length field.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-006 SHALL have ports in0_valid / in1_valid, input, 1 each, meaning requester 0 / requester 1 offers a posit.
REQ-007 SHALL have ports in0_bits / in1_bits, input, N each, meaning the posit offered.
REQ-008 SHALL have ports in0_ready / in1_ready, output, 1 each, meaning the offer is accepted this cycle.
REQ-009 SHALL have port out_valid, output, 1, meaning the decoded result register holds valid data.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-011 SHALL have port out_id, output, 1, meaning the requester index that produced the result.
REQ-012 SHALL have registered decode outputs: out_is_zero (1), out_is_inf (1), out_sign (1), out_reg_s (1), out_reg_len (S), out_k (N), out_exp (ES) and out_mant (N).

Function
REQ-013 SHALL contain exactly one posit_decode instance (N, S, ES passed through), shared by both requesters and fed by the granted requester's bits.
REQ-014 SHALL implement a two-state FSM:
- EMPTY: out_valid=0.
- FULL: out_valid=1.
REQ-015 SHALL define accept_ok = (state==EMPTY) || out_ready.
REQ-016 SHALL drive inX_ready=1 only when accept_ok=1 and requester X is granted; at most one inX_ready SHALL be high per cycle.
REQ-017 SHALL arbitrate as follows:
- If exactly one inX_valid=1, that requester is granted.
- If both are valid, the requester other than last_grant is granted.
REQ-018 SHALL define a transfer as inX_valid && inX_ready.
- On a transfer, the decoder outputs and out_id=X are captured into the result register.
- On a transfer, last_grant is set to X.
REQ-019 SHALL leave last_grant unchanged when no transfer occurs.
REQ-020 SHALL make FSM transitions as follows:
- EMPTY with a transfer -> FULL.
- EMPTY with no valid input -> EMPTY.
- FULL with out_ready=0 -> FULL; result is held stable and both inX_ready=0.
- FULL with out_ready=1 and a transfer -> FULL, with the new result loaded in the same cycle.
- FULL with out_ready=1 and no valid input -> EMPTY.
REQ-021 SHALL give a latency of one cycle: data accepted at edge t is presented with out_valid=1 after edge t.
REQ-022 SHALL sustain a throughput of one result per cycle while out_ready=1 and any input is valid.
REQ-023 SHALL keep inX_ready combinationally dependent only on state, out_ready, in0_valid, in1_valid and last_grant, never on inX_bits.
REQ-024 SHALL hold all out_* data fields constant whenever out_valid=1 and out_ready=0.
REQ-025 SHALL ensure that a requester holding valid never waits more than one accepted transfer of the other requester (round-robin fairness).

Reset
REQ-026 SHALL, on rst_n=0 and regardless of clk, immediately set state=EMPTY, out_valid=0, in0_ready=in1_ready=0, last_grant=1 (requester 0 wins the first contention), out_id=0 and all out_* data fields to 0.
REQ-027 SHALL discard any result held in the register, undelivered, when reset is asserted mid-operation; it SHALL NOT reappear after reset release.
REQ-028 SHALL allow the first transfer on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 SHALL pass this single-request scenario: after reset, in0_valid=1, in0_bits=0x40, out_ready=1 (N=8, ES=0) -> in0_ready=1 that cycle; next cycle out_valid=1, out_id=0, out_sign=0, out_reg_s=1, out_k=0, out_reg_len=2, out_mant=0x00.
REQ-030 SHALL pass this contention scenario: both valid continuously with in0_bits=0x60 and in1_bits=0x50, out_ready=1 -> out_id sequence 0,1,0,1; id0 results have out_k=1, out_reg_len=3; id1 results have out_k=0, out_mant=0x10.
REQ-031 SHALL pass this backpressure scenario: FULL with out_ready=0 for 3 cycles while in1_valid=1 -> in1_ready=0 throughout and out_* unchanged; on out_ready=1, in1 is accepted in that same cycle.
REQ-032 SHALL pass this special-value scenario: in0_bits=0x00 then 0x80 -> out_is_zero=1, then out_is_inf=1; out_sign=1 for 0x80.
REQ-033 SHALL pass this reset-mid-operation scenario: FULL with out_valid=1, assert rst_n=0 between edges -> out_valid=0 without a clk edge; after release, both requesters valid -> requester 0 is granted first.
REQ-034 SHALL pass this drain scenario: FULL, out_ready=1, no inputs valid -> next cycle out_valid=0, state EMPTY, last_grant unchanged.
